// File: rtl/branch_predictor_gen2.sv
// rtl/branch_predictor_gen2.sv - direction predictor: saturating counters, selectable indexing, checkpointed speculative GHR
module branch_predictor_gen2 #(
    parameter int ADDRESS_WIDTH = 22,
    parameter int INDEX_BITS    = 6,
    parameter int GHR_SIZE      = 6,
    parameter int CTR_BITS      = 2,
    parameter int STAT_WIDTH    = 16
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,
    input  logic [1:0]               i_Mode,
    input  logic                     i_Clear,
    input  logic [ADDRESS_WIDTH-1:0] i_IMEM_address,
    input  logic                     i_IMEM_isbranch,
    output logic                     o_taken,
    output logic [GHR_SIZE-1:0]      o_ghr,
    input  logic                     i_ALU_isbranch,
    input  logic [ADDRESS_WIDTH-1:0] i_ALU_pc,
    input  logic [GHR_SIZE-1:0]      i_ALU_ghr,
    input  logic                     i_ALU_prediction,
    input  logic                     i_ALU_outcome,
    output logic                     o_mispredict,
    output logic                     o_ready,
    output logic [STAT_WIDTH-1:0]    o_branch_count,
    output logic [STAT_WIDTH-1:0]    o_mispredict_count
);

    localparam int DEPTH = 1 << INDEX_BITS;
    localparam int G_SEL = INDEX_BITS / 2;
    localparam logic [CTR_BITS-1:0] WEAK_T = {1'b1, {(CTR_BITS-1){1'b0}}};

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [INDEX_BITS-1:0]   r_ptr;
    logic [GHR_SIZE-1:0]     r_ghr;
    logic [CTR_BITS-1:0]     r_table [DEPTH];
    logic [STAT_WIDTH-1:0]   r_branch_count;
    logic [STAT_WIDTH-1:0]   r_mispredict_count;

    logic                    w_ready;
    logic                    w_resolve;
    logic                    w_mispredict;
    logic                    w_taken;
    logic [INDEX_BITS-1:0]   w_fetch_idx;
    logic [INDEX_BITS-1:0]   w_alu_idx;
    logic [CTR_BITS-1:0]     w_fetch_ctr;
    logic [CTR_BITS-1:0]     w_alu_ctr;
    logic [CTR_BITS-1:0]     w_ctr_next;

    // Table index for a (pc, history) pair under the selected mode; mode 3 falls back to bimodal.
    function automatic logic [INDEX_BITS-1:0] f_index(
        input logic [1:0]               mode,
        input logic [ADDRESS_WIDTH-1:0] pc,
        input logic [GHR_SIZE-1:0]      h
    );
        logic [INDEX_BITS-1:0] h_ext;
        logic [INDEX_BITS-1:0] pc_lo;
        logic [INDEX_BITS-1:0] idx;
        h_ext = '0;
        h_ext[GHR_SIZE-1:0] = h;
        pc_lo = pc[INDEX_BITS-1:0];
        case (mode)
            2'd1:    idx = pc_lo ^ h_ext;
            2'd2:    idx = {h_ext[G_SEL-1:0], pc_lo[INDEX_BITS-G_SEL-1:0]};
            default: idx = pc_lo;
        endcase
        return idx;
    endfunction

    assign w_ready      = (r_state == ST_RUN);
    assign w_fetch_idx  = f_index(i_Mode, i_IMEM_address, r_ghr);
    assign w_alu_idx    = f_index(i_Mode, i_ALU_pc, i_ALU_ghr);
    assign w_fetch_ctr  = r_table[w_fetch_idx];
    assign w_alu_ctr    = r_table[w_alu_idx];
    assign w_taken      = w_ready & i_IMEM_isbranch & w_fetch_ctr[CTR_BITS-1];
    assign w_resolve    = w_ready & i_ALU_isbranch;
    assign w_mispredict = w_resolve & (i_ALU_outcome != i_ALU_prediction);

    assign o_taken            = w_taken;
    assign o_ghr              = r_ghr;
    assign o_mispredict       = w_mispredict;
    assign o_ready            = w_ready;
    assign o_branch_count     = r_branch_count;
    assign o_mispredict_count = r_mispredict_count;

    // Saturating step of the resolving branch's counter toward its actual outcome.
    always_comb begin
        w_ctr_next = w_alu_ctr;
        if (i_ALU_outcome) begin
            if (w_alu_ctr != '1) w_ctr_next = w_alu_ctr + CTR_BITS'(1);
        end else begin
            if (w_alu_ctr != '0) w_ctr_next = w_alu_ctr - CTR_BITS'(1);
        end
    end

    // State register.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) r_state <= ST_INIT;
        else            r_state <= w_state_next;
    end

    // Next state: clear always restarts the sweep; INIT leaves after writing the last entry.
    always_comb begin
        w_state_next = r_state;
        if (i_Clear) begin
            w_state_next = ST_INIT;
        end else begin
            case (r_state)
                ST_INIT: if (r_ptr == '1) w_state_next = ST_RUN;
                default: w_state_next = ST_RUN;
            endcase
        end
    end

    // Init sweep pointer; wraps back to zero as the sweep completes.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n)              r_ptr <= '0;
        else if (i_Clear)            r_ptr <= '0;
        else if (r_state == ST_INIT) r_ptr <= r_ptr + INDEX_BITS'(1);
    end

    // Counter table: weakly-taken fill during INIT, outcome training at resolution only.
    always_ff @(posedge i_Clk) begin
        if (r_state == ST_INIT) r_table[r_ptr] <= WEAK_T;
        else if (w_resolve)     r_table[w_alu_idx] <= w_ctr_next;
    end

    // Speculative history: a mispredict rebuilds from the checkpoint and overrides any fetch shift.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n)                       r_ghr <= '0;
        else if (i_Clear)                     r_ghr <= '0;
        else if (w_mispredict)                r_ghr <= {i_ALU_ghr[GHR_SIZE-2:0], i_ALU_outcome};
        else if (w_ready && i_IMEM_isbranch)  r_ghr <= {r_ghr[GHR_SIZE-2:0], w_taken};
    end

    // Saturating resolution and mispredict statistics.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (i_Clear) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_resolve) begin
            if (r_branch_count != '1)
                r_branch_count <= r_branch_count + STAT_WIDTH'(1);
            if (w_mispredict && (r_mispredict_count != '1))
                r_mispredict_count <= r_mispredict_count + STAT_WIDTH'(1);
        end
    end

endmodule
